// File: rtl/vga_pkg.sv
// Shared timing constants for the 1024x768@60 Hz VGA generator.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int H_VIS  = 1024;
  localparam int H_FP   = 24;
  localparam int H_SYNC = 136;
  localparam int H_BP   = 160;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS  = 768;
  localparam int V_FP   = 3;
  localparam int V_SYNC = 6;
  localparam int V_BP   = 29;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from vga_timing_gen to the draw pipeline.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic             line_start;
  logic             frame_start;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
  );

endinterface

// File: rtl/vga_mod_counter.sv
// Wrap-around counter 0..MAX with enable; carry marks the enabled wrap cycle.
module vga_mod_counter
  import vga_pkg::*;
#(
  parameter int unsigned MAX = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] next,
  output logic             carry
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX);

  assign carry = en && (count == LAST);

  always_comb begin
    next = count;
    if (en) begin
      next = carry ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing generator; all decodes are taken from next-state counters.
// Define VGA_SYNC_POS_EN for active-high syncs (default is active-low).
module vga_timing_gen #(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             en,
  vga_timing_gen_if.master vga
);
  import vga_pkg::*;

  localparam int H_LAST = H_VIS + H_FP + H_SYNC + H_BP - 1;
  localparam int V_LAST = V_VIS + V_FP + V_SYNC + V_BP - 1;

  localparam logic [CNT_W-1:0] HB_BEG = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VB_BEG = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

`ifdef VGA_SYNC_POS_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_carry;
  logic             v_carry;

  vga_mod_counter #(.MAX(H_LAST)) h_cnt (
    .clk   (pclk),
    .rst_n (rst_n),
    .en    (en),
    .count (vga.hcount),
    .next  (h_next),
    .carry (h_carry)
  );

  vga_mod_counter #(.MAX(V_LAST)) v_cnt (
    .clk   (pclk),
    .rst_n (rst_n),
    .en    (h_carry),
    .count (vga.vcount),
    .next  (v_next),
    .carry (v_carry)
  );

  // A carry means the counters land on column 0 (and row 0) at this edge,
  // so the pulses line up with the new position and are silent while frozen.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vga.hsync       <= ~SYNC_ON;
      vga.vsync       <= ~SYNC_ON;
      vga.hblnk       <= 1'b0;
      vga.vblnk       <= 1'b0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.hsync       <= (h_next >= HS_BEG && h_next <= HS_END) ? SYNC_ON : ~SYNC_ON;
      vga.vsync       <= (v_next >= VS_BEG && v_next <= VS_END) ? SYNC_ON : ~SYNC_ON;
      vga.hblnk       <= (h_next >= HB_BEG);
      vga.vblnk       <= (v_next >= VB_BEG);
      vga.line_start  <= h_carry;
      vga.frame_start <= v_carry;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running 1024x768@60 Hz VGA timing generator in the 65 MHz pixel-clock domain, directly downstream of the clock/reset stage. It consumes the pixel clock and the lock-qualified reset and produces pixel/line counters, sync and blanking strobes, and frame/line start pulses for the draw pipeline (background, rectangle, mouse overlay). All outputs are registered and mutually aligned.

## Interface
Parameters:
- H_VIS, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_VIS, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)

Ports:
- pclk  input  1  65 MHz pixel clock; only clock
- rst_n  input  1  asynchronous active-low reset; one clock (pclk), asynchronous active-low reset
- en  input  1  count enable; low freezes all state
- hcount  output  11  current pixel column, 0..H_TOT-1
- vcount  output  11  current line, 0..V_TOT-1
- hsync  output  1  horizontal sync (polarity per Configuration)
- vsync  output  1  vertical sync (polarity per Configuration)
- hblnk  output  1  high when hcount >= H_VIS
- vblnk  output  1  high when vcount >= V_VIS
- line_start  output  1  one-cycle pulse when hcount == 0
- frame_start  output  1  one-cycle pulse when hcount == 0 and vcount == 0

## Operation
- H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 1344; V_TOT = V_VIS+V_FP+V_SYNC+V_BP = 806.
- hcount increments each enabled cycle; at H_TOT-1 wraps to 0 and vcount increments; vcount at V_TOT-1 with hcount wrap goes to 0.
- hsync active for hcount in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [1048, 1183].
- vsync active for vcount in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [771, 776]; changes on same edge as hcount wrap.
- All decoded outputs computed from next-state counters and registered with them: every output describes the same (hcount, vcount) in the same cycle.
- en low: counters and all level outputs hold; line_start and frame_start forced 0. Resuming continues from the held position; a held position of hcount==0 does not re-pulse.
- Reset values (async, rst_n low): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync and vsync deasserted, line_start=0, frame_start=0.
- First frame after reset emits no frame_start/line_start for (0,0); first line_start at (0,1), first frame_start at next wrap to (0,0).
- Counter arithmetic 11-bit unsigned; no state reachable with hcount >= H_TOT or vcount >= V_TOT.

## Timing
- Latency: 0 cycles between counter value and its decodes (same register stage).
- Line period 1344 pclk cycles; frame period 1344*806 = 1,083,264 cycles (~16.67 ms at 65 MHz).
- rst_n assertion mid-frame: all outputs reach reset values immediately (async); release synchronised upstream, first count on first pclk edge after release.

## Configuration
- VGA_SYNC_POS_EN defined: hsync/vsync active-high, reset value 0.
- Not defined (default): hsync/vsync active-low (1024x768@60 standard), reset value 1.

## Structure
- Shared package vga_pkg: default timing constants (H_*/V_*, H_TOT, V_TOT), counter width constant (11).
- One sub-module: vga_mod_counter (parameterised wrap counter with enable, carry-out on wrap); instantiated twice, horizontal carry drives vertical enable.

## Test plan
- Reset then en=1 for 1344 cycles -> hcount 0..1343 then 0, vcount 0->1 on wrap, first line_start at (0,1).
- Scan one line -> hblnk rises at hcount=1024, hsync active exactly at 1048..1183 (136 cycles), deasserted at 1184.
- Run full frame -> vblnk high vcount 768..805, vsync active vcount 771..776, frame_start single pulse at (0,0) after 1,083,264 cycles.
- Drop en at (500,10) for 100 cycles -> all outputs hold, no pulses; resume at (501,10).
- Assert rst_n low at (1100,775) -> outputs immediately hcount=0, vcount=0, syncs deasserted, blanks 0.
- Compile with VGA_SYNC_POS_EN -> hsync high 1048..1183, reset value 0; polarity inverted vs default run.
